// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants, shadow-stage record and match/forward helpers for the
// pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef struct packed {
    logic       wr;
    logic [4:0] dst;
    logic [1:0] tnew;
  } stageEntry_t;

  // $0 is hardwired, so it never counts as a producer.
  function automatic logic stageMatch(stageEntry_t s, logic [4:0] src);
    return s.wr && (s.dst == src) && (s.dst != 5'd0);
  endfunction

  function automatic logic opStall(stageEntry_t s, logic [4:0] src, logic [1:0] tuse);
    return stageMatch(s, src) && (tuse != TUSE_NONE) && (s.tnew > tuse);
  endfunction

  // Youngest producer wins; if it is not ready yet nothing older may be used.
  function automatic logic [1:0] fwdSelD(stageEntry_t e, stageEntry_t m, stageEntry_t w,
                                         logic [4:0] src);
    if (stageMatch(e, src)) return (e.tnew == 2'd0) ? FWD_E : FWD_RF;
    if (stageMatch(m, src)) return (m.tnew == 2'd0) ? FWD_M : FWD_RF;
    if (stageMatch(w, src)) return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic [1:0] fwdSelE(stageEntry_t m, stageEntry_t w, logic [4:0] src);
    if (stageMatch(m, src) && (m.tnew == 2'd0)) return FWD_M;
    if (stageMatch(w, src)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md.sv
// HI/LO busy counter: loads the op latency on an accepted start, then counts
// down to zero; busy while nonzero.
module md_busy_cnt #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic op,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (start)          cnt <= op ? DIV_LD : MULT_LD;
    else if (cnt != '0)      cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding control for a 5-stage MIPS-style pipeline using a
// shadow copy of {wr, dst, tnew} for E, M and W.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [1:0] tuse_rsD,
  input  logic [1:0] tuse_rtD,
  input  logic       regwriteD,
  input  logic [4:0] dstD,
  input  logic [1:0] tnewD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic       md_startD,
  input  logic       md_opD,
  input  logic       md_useD,
  output logic       stallF,
  output logic       stallD,
  output logic       flushE,
  output logic [1:0] fwd_rsD,
  output logic [1:0] fwd_rtD,
  output logic [1:0] fwd_rsE,
  output logic [1:0] fwd_rtE,
  output logic       md_busy
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  stageEntry_t shE, shM, shW;
  stageEntry_t nextE, nextM, nextW;
  logic        dataStall, mdStall, stall;

  always_comb begin
    dataStall = opStall(shE, rsD, tuse_rsD) || opStall(shM, rsD, tuse_rsD) ||
                opStall(shE, rtD, tuse_rtD) || opStall(shM, rtD, tuse_rtD);
    mdStall   = md_useD && md_busy;
    stall     = dataStall || mdStall;
  end

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;

  assign fwd_rsD = fwdSelD(shE, shM, shW, rsD);
  assign fwd_rtD = fwdSelD(shE, shM, shW, rtD);
  assign fwd_rsE = fwdSelE(shM, shW, rsE);
  assign fwd_rtE = fwdSelE(shM, shW, rtE);

  // A stalled D instruction enters E as a bubble; older stages keep moving.
  always_comb begin
    nextE      = '0;
    nextM      = '0;
    nextW      = '0;
    if (!stall) begin
      nextE.wr   = regwriteD;
      nextE.dst  = dstD;
      nextE.tnew = tnewD;
    end
    nextM.wr   = shE.wr;
    nextM.dst  = shE.dst;
    nextM.tnew = (shE.tnew == 2'd0) ? 2'd0 : shE.tnew - 2'd1;
    nextW.wr   = shM.wr;
    nextW.dst  = shM.dst;
    nextW.tnew = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shE <= '0;
      shM <= '0;
      shW <= '0;
    end else begin
      shE <= nextE;
      shM <= nextM;
      shW <= nextW;
    end
  end

  md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_mdCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_startD && !stall),
    .op    (md_opD),
    .busy  (md_busy)
  );

endmodule
